// File: rtl/shift_sub_divider_pkg.sv
// shift_sub_divider_pkg: shared state encoding and default width for the shift/subtract divider
package shift_sub_divider_pkg;
  localparam int DIV_N = 8;
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_SUB   = 2'd2,
    S_DONE  = 2'd3
  } state_t;
endpackage

// File: rtl/div_control.sv
// div_control: divider controller FSM with the per-bit iteration counter
// Ports: Clk, Rst (async, active-high), St start, Dz divisor-is-zero at load;
//        Idle, Done state decodes, Load accept strobe, Sh shift step, Su subtract step.
module div_control
  import shift_sub_divider_pkg::*;
#(
  parameter int N = DIV_N
) (
  input  logic Clk,
  input  logic Rst,
  input  logic St,
  input  logic Dz,
  output logic Idle,
  output logic Done,
  output logic Load,
  output logic Sh,
  output logic Su
);
  localparam int KW = $clog2(N + 1);
  state_t state;
  logic [KW-1:0] k;
  assign Idle = state == S_IDLE;
  assign Done = state == S_DONE;
  assign Sh = state == S_SHIFT;
  assign Su = state == S_SUB;
  assign Load = Idle & St;
  always_ff @(posedge Clk or posedge Rst)
    if (Rst) begin
      state <= S_IDLE;
      k <= '0;
    end else
      case (state)
        S_IDLE: if (St) begin
          k <= KW'(N);
          state <= Dz ? S_DONE : S_SHIFT;
        end
        S_SHIFT: state <= S_SUB;
        S_SUB: begin
          k <= k - KW'(1);
          state <= (k == KW'(1)) ? S_DONE : S_SHIFT;
        end
        default: state <= S_IDLE;
      endcase
endmodule

// File: rtl/shift_sub_divider.sv
// shift_sub_divider: sequential unsigned restoring divider, one quotient bit per shift/subtract pair
// Ports: Clk, Rst (async, active-high), St start, Dividend, Divisor;
//        Idle, Done (one-cycle pulse), DivZero, Quotient, Remainder (valid from Done).
module shift_sub_divider
  import shift_sub_divider_pkg::*;
#(
  parameter int N = DIV_N
) (
  input  logic         Clk,
  input  logic         Rst,
  input  logic         St,
  input  logic [N-1:0] Dividend,
  input  logic [N-1:0] Divisor,
  output logic         Idle,
  output logic         Done,
  output logic         DivZero,
  output logic [N-1:0] Quotient,
  output logic [N-1:0] Remainder
);
  logic [N:0] a;
  logic [N-1:0] q, b;
  logic [N+1:0] diff;
  logic load, sh, su, dz;
  assign dz = Divisor == '0;
  // A can reach 2^(N+1)-1 after a shift, so one extra bit keeps the borrow honest
  assign diff = {1'b0, a} - {2'b00, b};
  assign Quotient = q;
  assign Remainder = a[N-1:0];
  div_control #(.N(N)) u_ctl (
    .Clk(Clk), .Rst(Rst), .St(St), .Dz(dz),
    .Idle(Idle), .Done(Done), .Load(load), .Sh(sh), .Su(su)
  );
  // divide-by-zero short-cuts straight to the final result at load time so it is valid during Done
  always_ff @(posedge Clk or posedge Rst)
    if (Rst) begin
      a <= '0;
      q <= '0;
      b <= '0;
      DivZero <= 1'b0;
    end else if (load) begin
      a <= dz ? {1'b0, Dividend} : '0;
      q <= dz ? '1 : Dividend;
      b <= Divisor;
      DivZero <= dz;
    end else if (sh)
      {a, q} <= {a[N-1:0], q, 1'b0};
    else if (su && !diff[N+1]) begin
      a <= diff[N:0];
      q[0] <= 1'b1;
    end
endmodule

// File: tb/tb_shift_sub_divider.sv
// tb_shift_sub_divider: scoreboard bench for the restoring divider
module tb_shift_sub_divider;
  typedef struct packed {
    logic [7:0] q;
    logic [7:0] r;
    logic       dz;
  } exp_t;
  logic Clk = 1'b0, Rst = 1'b1, St = 1'b0;
  logic [7:0] Dividend = '0, Divisor = '0;
  logic Idle, Done, DivZero;
  logic [7:0] Quotient, Remainder;
  exp_t sb[$];
  exp_t got;
  int nvec = 0, nerr = 0;
  shift_sub_divider #(.N(8)) dut (
    .Clk(Clk), .Rst(Rst), .St(St), .Dividend(Dividend), .Divisor(Divisor),
    .Idle(Idle), .Done(Done), .DivZero(DivZero), .Quotient(Quotient), .Remainder(Remainder)
  );
  always #5 Clk = ~Clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask
  always @(negedge Clk)
    if (Done) begin
      if (sb.size() == 0) check("spurious_done", Done, 0);
      else begin
        got = sb.pop_front();
        check("quotient", Quotient, got.q);
        check("remainder", Remainder, got.r);
        check("divzero", DivZero, got.dz);
        check("idle_in_done", Idle, 0);
      end
    end
  function automatic exp_t model(input logic [7:0] dd, input logic [7:0] dv);
    exp_t e;
    e.dz = dv == 0;
    e.q = e.dz ? 8'hff : dd / dv;
    e.r = e.dz ? dd : dd % dv;
    return e;
  endfunction
  task automatic do_div(input logic [7:0] dd, input logic [7:0] dv);
    int n;
    @(negedge Clk);
    check("idle_before_start", Idle, 1);
    St = 1'b1; Dividend = dd; Divisor = dv;
    sb.push_back(model(dd, dv));
    n = 0;
    do begin
      @(negedge Clk);
      n++;
      St = (n == 3);
      Dividend = 8'($urandom);
      Divisor = 8'($urandom);
    end while (!Done && n < 60);
    St = 1'b0;
    check("done_seen", Done, 1);
    check("latency", n, dv == 0 ? 1 : 17);
  endtask
  initial begin
    int n;
    #12;
    check("rst_idle", Idle, 1);
    check("rst_done", Done, 0);
    check("rst_q", Quotient, 0);
    check("rst_r", Remainder, 0);
    check("rst_dz", DivZero, 0);
    @(negedge Clk);
    Rst = 1'b0;
    do_div(100, 7);
    do_div(5, 9);
    do_div(255, 1);
    do_div(255, 255);
    do_div(200, 0);
    do_div(100, 7);
    @(negedge Clk);
    St = 1'b1; Dividend = 100; Divisor = 7;
    @(negedge Clk);
    St = 1'b0;
    repeat (4) @(negedge Clk);
    #2 Rst = 1'b1;
    #1;
    check("midrst_idle", Idle, 1);
    check("midrst_q", Quotient, 0);
    check("midrst_r", Remainder, 0);
    check("midrst_dz", DivZero, 0);
    repeat (3) @(negedge Clk);
    Rst = 1'b0;
    repeat (20) @(negedge Clk);
    check("midrst_no_done", Idle, 1);
    do_div(100, 7);
    @(negedge Clk);
    St = 1'b1; Dividend = 100; Divisor = 7;
    repeat (3) sb.push_back(model(100, 7));
    for (int i = 0; i < 3; i++) begin
      n = 0;
      do begin
        @(negedge Clk);
        n++;
      end while (!Done && n < 60);
      check("b2b_done", Done, 1);
      check(i == 0 ? "b2b_latency" : "b2b_gap", n, i == 0 ? 17 : 18);
      if (i == 2) St = 1'b0;
    end
    repeat (3) @(negedge Clk);
    check("hold_idle", Idle, 1);
    check("hold_q", Quotient, 14);
    check("hold_r", Remainder, 2);
    for (int i = 0; i < 6; i++) do_div(8'($urandom), 8'($urandom_range(1, 255)));
    do_div(0, 0);
    repeat (2) @(negedge Clk);
    check("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
